// File: rtl/sensor_request_hub_pkg.sv
// Command/response codes and FSM states shared by the sensor request hub.
package sensor_pkg;

   localparam logic [7:0] CMD_STATUS    = 8'h00;
   localparam logic [7:0] CMD_TEMP      = 8'h01;
   localparam logic [7:0] CMD_HUM       = 8'h02;
   localparam logic [7:0] CMD_LOOP_TEMP = 8'h03;
   localparam logic [7:0] CMD_LOOP_HUM  = 8'h04;
   localparam logic [7:0] CMD_STOP_TEMP = 8'h05;
   localparam logic [7:0] CMD_STOP_HUM  = 8'h06;

   localparam logic [7:0] RSP_OK       = 8'h07;
   localparam logic [7:0] RSP_HUM      = 8'h08;
   localparam logic [7:0] RSP_TEMP     = 8'h09;
   localparam logic [7:0] RSP_STOPPED  = 8'h0A;
   localparam logic [7:0] RSP_FAIL     = 8'h1F;
   localparam logic [7:0] RSP_UNKNOWN  = 8'h45;
   localparam logic [7:0] RSP_NO_LOOP  = 8'hAA;
   localparam logic [7:0] RSP_BAD_ADDR = 8'hEA;
   localparam logic [7:0] RSP_IN_LOOP  = 8'hFF;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_READ,
      ST_LOOP_READ,
      ST_LOOP_WAIT
   } hub_state_e;

   function automatic logic isStopCmd(input logic [7:0] cmd);
      return (cmd == CMD_STOP_TEMP) || (cmd == CMD_STOP_HUM);
   endfunction

endpackage

// File: rtl/sensor_request_hub_if.sv
// Request/response bus between the UART command decoder and the sensor hub.
interface sensor_request_hub_if;

   logic       enable;
   logic [7:0] request_command;
   logic [7:0] request_address;
   logic       ready;
   logic       response_valid;
   logic [7:0] response_command;
   logic [7:0] response_value;

   modport master (
      output enable, request_command, request_address,
      input  ready, response_valid, response_command, response_value
   );

   modport slave (
      input  enable, request_command, request_address,
      output ready, response_valid, response_command, response_value
   );

endinterface

// File: rtl/sensor_request_hub_frame_check.sv
// Splits a 40-bit DHT11 frame and validates its additive checksum byte.
module sensor_frame_check (
   input  logic [39:0] frame,
   output logic        checksum_ok,
   output logic [7:0]  temp_int,
   output logic [7:0]  hum_int
);

   logic [7:0] byteSum;

   // Byte order is hum_int, hum_dec, temp_int, temp_dec, checksum (LSB).
   assign byteSum     = frame[39:32] + frame[31:24] + frame[23:16] + frame[15:8];
   assign checksum_ok = (byteSum == frame[7:0]);
   assign temp_int    = frame[23:16];
   assign hum_int     = frame[39:32];

endmodule

// File: rtl/sensor_request_hub.sv
// Accepts requests for one of NUM_SENSORS channels, runs one-shot or periodic
// reads with a timeout, and reports each outcome as a one-cycle response.
module sensor_request_hub
   import sensor_pkg::*;
#(
   parameter int NUM_SENSORS        = 4,
   parameter int POLL_PERIOD_CYCLES = 100000000,
   parameter int TIMEOUT_CYCLES     = 50000000,
   parameter int CNT_W              = 27
) (
   input  logic                      clock,
   input  logic                      reset,
   sensor_request_hub_if.slave       req,
   output logic [NUM_SENSORS-1:0]    sensor_enable,
   input  logic [40*NUM_SENSORS-1:0] sensor_data,
   input  logic [NUM_SENSORS-1:0]    sensor_error,
   input  logic [NUM_SENSORS-1:0]    sensor_done
);

   localparam int AW = (NUM_SENSORS > 1) ? $clog2(NUM_SENSORS) : 1;
   localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
   localparam logic [CNT_W-1:0] POLL_LAST    = CNT_W'(POLL_PERIOD_CYCLES - 1);

   hub_state_e       state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [AW-1:0]    addr_q, addr_d;
   logic [7:0]       cmd_q, cmd_d;
   logic             rspValid_q, rspValid_d;
   logic [15:0]      rsp_q, rsp_d;

   logic [39:0] frames [NUM_SENSORS];
   logic        chDone, chError, checksumOk, frameGood, busy;
   logic [7:0]  tempInt, humInt;

   for (genvar i = 0; i < NUM_SENSORS; i++) begin : g_frames
      assign frames[i] = sensor_data[40*i +: 40];
   end

   sensor_frame_check u_frameCheck (
      .frame      (frames[addr_q]),
      .checksum_ok(checksumOk),
      .temp_int   (tempInt),
      .hum_int    (humInt)
   );

   assign chDone    = sensor_done[addr_q];
   assign chError   = sensor_error[addr_q];
   assign frameGood = chDone && !chError && checksumOk;
   assign busy      = (state_q == ST_READ) || (state_q == ST_LOOP_READ);

   assign sensor_enable        = busy ? (NUM_SENSORS'(1) << addr_q) : '0;
   assign req.ready            = (state_q == ST_IDLE) || (state_q == ST_LOOP_WAIT);
   assign req.response_valid   = rspValid_q;
   assign req.response_command = rsp_q[15:8];
   assign req.response_value   = rsp_q[7:0];

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q + 1'b1;
      addr_d     = addr_q;
      cmd_d      = cmd_q;
      rspValid_d = 1'b0;
      rsp_d      = rsp_q;
      case (state_q)
         ST_IDLE: begin
            cnt_d = '0;
            if (req.enable) begin
               if (req.request_address >= 8'(NUM_SENSORS)) begin
                  rspValid_d = 1'b1;
                  rsp_d      = {RSP_BAD_ADDR, RSP_BAD_ADDR};
               end else if (isStopCmd(req.request_command)) begin
                  rspValid_d = 1'b1;
                  rsp_d      = {RSP_NO_LOOP, RSP_NO_LOOP};
               end else if (req.request_command > CMD_STOP_HUM) begin
                  rspValid_d = 1'b1;
                  rsp_d      = {RSP_UNKNOWN, RSP_UNKNOWN};
               end else begin
                  addr_d  = req.request_address[AW-1:0];
                  cmd_d   = req.request_command;
                  state_d = (req.request_command <= CMD_HUM) ? ST_READ : ST_LOOP_READ;
               end
            end
         end
         ST_READ, ST_LOOP_READ: begin
            if (chDone || (cnt_q == TIMEOUT_LAST)) begin
               rspValid_d = 1'b1;
               cnt_d      = '0;
               state_d    = (state_q == ST_READ) ? ST_IDLE : ST_LOOP_WAIT;
               if (!frameGood)
                  rsp_d = {RSP_FAIL, RSP_FAIL};
               else if (cmd_q == CMD_STATUS)
                  rsp_d = {RSP_OK, RSP_OK};
               else if ((cmd_q == CMD_TEMP) || (cmd_q == CMD_LOOP_TEMP))
                  rsp_d = {RSP_TEMP, tempInt};
               else
                  rsp_d = {RSP_HUM, humInt};
            end
         end
         ST_LOOP_WAIT: begin
            if (req.enable) begin
               rspValid_d = 1'b1;
               if (isStopCmd(req.request_command)) begin
                  rsp_d   = {RSP_STOPPED, 8'h00};
                  state_d = ST_IDLE;
                  cnt_d   = '0;
                  cmd_d   = CMD_STATUS;
                  addr_d  = '0;
               end else begin
                  rsp_d = {RSP_IN_LOOP, RSP_IN_LOOP};
                  // A request on the expiry edge holds the counter so expiry fires next cycle.
                  if (cnt_q == POLL_LAST)
                     cnt_d = cnt_q;
               end
            end else if (cnt_q == POLL_LAST) begin
               state_d = ST_LOOP_READ;
               cnt_d   = '0;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q    <= ST_IDLE;
         cnt_q      <= '0;
         addr_q     <= '0;
         cmd_q      <= CMD_STATUS;
         rspValid_q <= 1'b0;
         rsp_q      <= '0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         addr_q     <= addr_d;
         cmd_q      <= cmd_d;
         rspValid_q <= rspValid_d;
         rsp_q      <= rsp_d;
      end
   end

endmodule

// File: tb/tb_sensor_request_hub.sv
// Randomized self-checking bench for sensor_request_hub with a behavioural
// sensor model and a timeline-based expectation of reads and loop sampling.
module tb_sensor_request_hub;

   localparam int NS   = 4;
   localparam int POLL = 20;
   localparam int TMO  = 50;

   logic clock = 1'b0;
   logic reset;
   always #5 clock = ~clock;

   sensor_request_hub_if hubIf ();

   logic [NS-1:0]    sensorEnable;
   logic [NS-1:0]    sensorError;
   logic [NS-1:0]    sensorDone = '0;
   logic [40*NS-1:0] sensorData;

   int doneDelay  = 1000;
   int highCount  = 0;
   int checkCount = 0;
   int failCount  = 0;

   sensor_request_hub #(
      .NUM_SENSORS       (NS),
      .POLL_PERIOD_CYCLES(POLL),
      .TIMEOUT_CYCLES    (TMO),
      .CNT_W             (8)
   ) dut (
      .clock        (clock),
      .reset        (reset),
      .req          (hubIf),
      .sensor_enable(sensorEnable),
      .sensor_data  (sensorData),
      .sensor_error (sensorError),
      .sensor_done  (sensorDone)
   );

   // Sensor model: the enabled channel reports done in its doneDelay-th enabled cycle.
   always @(negedge clock) begin
      if (sensorEnable != '0) highCount = highCount + 1;
      else                    highCount = 0;
      sensorDone = ((sensorEnable != '0) && (highCount == doneDelay)) ? sensorEnable : '0;
   end

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checkCount++;
      if (observed !== expected) begin
         failCount++;
         $display("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   task automatic applyStimulus(input logic [7:0] cmd, input logic [7:0] addr);
      hubIf.enable          = 1'b1;
      hubIf.request_command = cmd;
      hubIf.request_address = addr;
      @(negedge clock);
      hubIf.enable          = 1'b0;
   endtask

   function automatic logic [39:0] makeFrame(input logic good);
      logic [7:0] b4, b3, b2, b1, ck;
      int s;
      b4 = 8'($urandom);
      b3 = 8'($urandom);
      b2 = 8'($urandom);
      b1 = 8'($urandom);
      s  = (int'(b4) + int'(b3) + int'(b2) + int'(b1)) % 256;
      ck = good ? 8'(s) : 8'((s + 1 + $urandom_range(0, 254)) % 256);
      return {b4, b3, b2, b1, ck};
   endfunction

   function automatic logic [15:0] expectRead(input logic [7:0] cmd, input logic [39:0] frame,
                                              input logic err, input int delay);
      int s;
      s = (int'(frame[39:32]) + int'(frame[31:24]) + int'(frame[23:16]) + int'(frame[15:8])) % 256;
      if (delay > TMO || err || s != int'(frame[7:0])) return 16'h1F1F;
      if (cmd == 8'h00) return 16'h0707;
      if (cmd == 8'h01 || cmd == 8'h03) return {8'h09, frame[23:16]};
      return {8'h08, frame[39:32]};
   endfunction

   function automatic logic [15:0] expectImmediate(input logic [7:0] cmd, input logic [7:0] addr);
      if (int'(addr) >= NS) return 16'hEAEA;
      if (cmd == 8'h05 || cmd == 8'h06) return 16'hAAAA;
      return 16'h4545;
   endfunction

   task automatic setChannels(input int addr, input logic [39:0] frame, input logic err);
      logic [63:0] noise;
      for (int i = 0; i < NS; i++) begin
         noise = {$urandom(), $urandom()};
         sensorData[40*i +: 40] = noise[39:0];
      end
      sensorError             = NS'($urandom());
      sensorData[40*addr +: 40] = frame;
      sensorError[addr]       = err;
   endtask

   task automatic immediateCase(input logic [7:0] cmd, input logic [7:0] addr);
      applyStimulus(cmd, addr);
      checkOutput("imm_valid", hubIf.response_valid, 1);
      checkOutput("imm_rsp", {hubIf.response_command, hubIf.response_value}, expectImmediate(cmd, addr));
      checkOutput("imm_enable", sensorEnable, 0);
      checkOutput("imm_ready", hubIf.ready, 1);
      @(negedge clock);
      checkOutput("imm_valid_drop", hubIf.response_valid, 0);
   endtask

   task automatic readCase(input int addr, input logic [7:0] cmd, input logic [39:0] frame,
                           input logic err, input int delay);
      logic [NS-1:0] oh;
      int highSeen;
      int expHigh;
      oh       = NS'(1) << addr;
      highSeen = 0;
      expHigh  = (delay < TMO) ? delay : TMO;
      setChannels(addr, frame, err);
      doneDelay = delay;
      applyStimulus(cmd, 8'(addr));
      checkOutput("read_ready_busy", hubIf.ready, 0);
      for (int b = 0; b < 200 && sensorEnable == oh && !hubIf.response_valid; b++) begin
         highSeen++;
         @(negedge clock);
      end
      checkOutput("read_enable_cycles", highSeen, expHigh);
      checkOutput("read_valid", hubIf.response_valid, 1);
      checkOutput("read_enable_off", sensorEnable, 0);
      checkOutput("read_rsp", {hubIf.response_command, hubIf.response_value}, expectRead(cmd, frame, err, delay));
      @(negedge clock);
      checkOutput("read_valid_drop", hubIf.response_valid, 0);
      checkOutput("read_idle_enable", sensorEnable, 0);
   endtask

   // Loop expectation: bursts of min(delay,TMO) enabled cycles, a response at the end
   // of each, then POLL idle cycles (one more if a request lands on the last one).
   task automatic loopCase(input int addr, input logic [7:0] cmd, input logic [39:0] frame,
                           input logic err, input int delay, input int samples, input int injOff);
      int starts[8];
      int burst, injectAt, stopAt, ignoreAt, lastCycle;
      logic [NS-1:0] oh;
      logic [15:0] sampleRsp, expRsp;
      logic expEn, expValid;
      logic [7:0] midCmd;
      oh        = NS'(1) << addr;
      burst     = (delay < TMO) ? delay : TMO;
      sampleRsp = expectRead(cmd, frame, err, delay);
      starts[0] = 0;
      for (int j = 1; j < samples; j++)
         starts[j] = starts[j-1] + burst + POLL + ((j - 1 == 1 && injOff == POLL - 1) ? 1 : 0);
      injectAt  = starts[1] + burst + injOff;
      stopAt    = starts[samples-1] + burst + $urandom_range(0, POLL - 1);
      ignoreAt  = (burst >= 2) ? 1 : -1;
      lastCycle = stopAt + 6;
      midCmd    = 8'($urandom_range(0, 255));
      if (midCmd == 8'h05 || midCmd == 8'h06) midCmd = 8'h01;
      setChannels(addr, frame, err);
      doneDelay = delay;
      applyStimulus(cmd, 8'(addr));
      for (int c = 0; c <= lastCycle; c++) begin
         expEn    = 1'b0;
         expValid = 1'b0;
         expRsp   = 16'h0000;
         for (int j = 0; j < samples; j++) begin
            if (c >= starts[j] && c < starts[j] + burst) expEn = 1'b1;
            if (c == starts[j] + burst) begin
               expValid = 1'b1;
               expRsp   = sampleRsp;
            end
         end
         if (c == injectAt + 1) begin
            expValid = 1'b1;
            expRsp   = 16'hFFFF;
         end
         if (c == stopAt + 1) begin
            expValid = 1'b1;
            expRsp   = 16'h0A00;
         end
         checkOutput("loop_enable", sensorEnable, expEn ? oh : '0);
         checkOutput("loop_ready", hubIf.ready, !expEn);
         checkOutput("loop_valid", hubIf.response_valid, expValid);
         if (expValid)
            checkOutput("loop_rsp", {hubIf.response_command, hubIf.response_value}, expRsp);
         hubIf.enable = 1'b0;
         if (c == injectAt) begin
            hubIf.enable          = 1'b1;
            hubIf.request_command = midCmd;
            hubIf.request_address = 8'($urandom());
         end else if (c == stopAt) begin
            hubIf.enable          = 1'b1;
            hubIf.request_command = ($urandom_range(0, 1) == 0) ? 8'h05 : 8'h06;
            hubIf.request_address = 8'($urandom());
         end else if (c == ignoreAt) begin
            hubIf.enable          = 1'b1;
            hubIf.request_command = 8'h05;
            hubIf.request_address = 8'(addr);
         end
         @(negedge clock);
      end
      hubIf.enable = 1'b0;
   endtask

   initial begin
      logic [7:0] rc, ra;
      hubIf.enable          = 1'b0;
      hubIf.request_command = 8'h00;
      hubIf.request_address = 8'h00;
      sensorError           = '0;
      sensorData            = '0;
      reset                 = 1'b1;
      repeat (2) @(negedge clock);
      checkOutput("reset_ready", hubIf.ready, 1);
      checkOutput("reset_valid", hubIf.response_valid, 0);
      checkOutput("reset_rsp", {hubIf.response_command, hubIf.response_value}, 0);
      checkOutput("reset_enable", sensorEnable, 0);
      reset = 1'b0;
      @(negedge clock);

      readCase(2, 8'h01, 40'h37001A0051, 1'b0, 10);
      readCase(1, 8'h02, 40'h37001A0052, 1'b0, 7);
      readCase(3, 8'h02, 40'h37001A0051, 1'b1, 5);
      readCase(0, 8'h00, 40'h37001A0051, 1'b0, 1000);
      readCase(1, 8'h00, 40'h37001A0051, 1'b0, TMO);
      immediateCase(8'h01, 8'd4);
      immediateCase(8'h05, 8'd0);
      immediateCase(8'h09, 8'd1);
      loopCase(0, 8'h04, 40'h37001A0051, 1'b0, 10, 4, POLL - 1);

      for (int n = 0; n < 20; n++) begin
         if ($urandom_range(0, 1) == 0) begin
            ra = 8'($urandom_range(NS, 255));
            rc = 8'($urandom());
         end else begin
            ra = 8'($urandom_range(0, NS - 1));
            rc = ($urandom_range(0, 1) == 0) ? 8'($urandom_range(5, 6)) : 8'($urandom_range(7, 255));
         end
         immediateCase(rc, ra);
      end

      for (int n = 0; n < 20; n++)
         readCase($urandom_range(0, NS - 1), 8'($urandom_range(0, 2)),
                  makeFrame($urandom_range(0, 9) < 7), $urandom_range(0, 9) < 2,
                  $urandom_range(1, TMO + 10));

      for (int n = 0; n < 3; n++)
         loopCase($urandom_range(0, NS - 1), 8'($urandom_range(3, 4)),
                  makeFrame($urandom_range(0, 9) < 8), 1'b0,
                  $urandom_range(2, TMO + 5), 3 + n, $urandom_range(0, POLL - 1));

      setChannels(1, makeFrame(1'b1), 1'b0);
      doneDelay = 30;
      applyStimulus(8'h03, 8'd1);
      repeat (3) @(negedge clock);
      checkOutput("rst_pre_enable", sensorEnable, 4'b0010);
      reset = 1'b1;
      @(negedge clock);
      checkOutput("rst_enable", sensorEnable, 0);
      checkOutput("rst_ready", hubIf.ready, 1);
      checkOutput("rst_valid", hubIf.response_valid, 0);
      checkOutput("rst_rsp", {hubIf.response_command, hubIf.response_value}, 0);
      reset = 1'b0;
      immediateCase(8'h05, 8'd1);

      $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
      $finish;
   end

endmodule
